// File: rtl/pipeline_spi_command_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipeline_spi_command_master_if: command, status and SPI pin bundle |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface pipeline_spi_command_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [15:0] cmd_arg;
  logic        busy;
  logic        frame_done;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        hw_spi_clk;
  logic        hw_spi_ss;
  logic        hw_spi_mosi;
  logic        hw_spi_miso;

  // master: the SPI command master itself; slave: the command source / pin consumer
  modport master (
    input  cmd_valid, cmd_opcode, cmd_arg, hw_spi_miso,
    output cmd_ready, busy, frame_done, rx_byte, rx_valid,
           hw_spi_clk, hw_spi_ss, hw_spi_mosi
  );
  modport slave (
    output cmd_valid, cmd_opcode, cmd_arg, hw_spi_miso,
    input  cmd_ready, busy, frame_done, rx_byte, rx_valid,
           hw_spi_clk, hw_spi_ss, hw_spi_mosi
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_spi_command_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipeline_spi_command_master: mode-0 SPI master, one command/frame  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pipeline_spi_command_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  pipeline_spi_command_master_if.master         bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  // Payload byte count must track the control decoder's command map.
  function automatic logic [1:0] payload_len(input logic [7:0] op);
    logic [1:0] n;
    case (op)
      8'h00, 8'hFF:                      n = 2'd0;
      8'h01, 8'h02, 8'h03, 8'h06, 8'h0B: n = 2'd1;
      default:                           n = 2'd2;
    endcase
    return n;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [23:0] tx_q, tx_d;
  logic [4:0]  bits_q, bits_d;
  logic        last_q, last_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        sck_q, sck_d;
  logic        ss_q, ss_d;
  logic        mosi_q, mosi_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        accept;
  logic        rise;
  logic [7:0]  rx_next;

  assign accept  = bus.cmd_valid & cmd_ready_q;
  assign rx_next = {rx_sh_q[6:0], bus.hw_spi_miso};

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    tx_d         = tx_q;
    bits_d       = bits_q;
    last_d       = last_q;
    rx_sh_d      = rx_sh_q;
    rx_byte_d    = rx_byte_q;
    rx_valid_d   = 1'b0;
    sck_d        = sck_q;
    ss_d         = ss_q;
    mosi_d       = mosi_q;
    frame_done_d = 1'b0;
    rise         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          div_d   = DIV_LOAD;
          ss_d    = 1'b0;
          mosi_d  = bus.cmd_opcode[7];
          last_d  = 1'b0;
          case (payload_len(bus.cmd_opcode))
            2'd0: begin
              tx_d   = {bus.cmd_opcode, 16'h0000};
              bits_d = 5'd7;
            end
            2'd1: begin
              tx_d   = {bus.cmd_opcode, bus.cmd_arg[7:0], 8'h00};
              bits_d = 5'd15;
            end
            default: begin
              tx_d   = {bus.cmd_opcode, bus.cmd_arg};
              bits_d = 5'd23;
            end
          endcase
        end
      end

      S_SETUP: begin
        if (div_q == 8'd0) begin
          state_d = S_SHIFT;
          div_d   = DIV_LOAD;
          sck_d   = 1'b1;
          rise    = 1'b1;
        end else begin
          div_d = div_q - 8'd1;
        end
      end

      S_SHIFT: begin
        if (div_q != 8'd0) begin
          div_d = div_q - 8'd1;
        end else begin
          div_d = DIV_LOAD;
          if (sck_q) begin
            // Falling edge: present the next bit; bits_q==0 marks the frame's final bit.
            sck_d  = 1'b0;
            tx_d   = {tx_q[22:0], 1'b0};
            mosi_d = tx_q[22];
            if (bits_q == 5'd0) begin
              last_d = 1'b1;
            end else begin
              bits_d = bits_q - 5'd1;
            end
          end else if (last_q) begin
            state_d = S_HOLD;
          end else begin
            sck_d = 1'b1;
            rise  = 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (div_q == 8'd0) begin
          state_d      = S_GAP;
          div_d        = GAP_LOAD;
          ss_d         = 1'b1;
          mosi_d       = 1'b0;
          frame_done_d = 1'b1;
        end else begin
          div_d = div_q - 8'd1;
        end
      end

      S_GAP: begin
        if (div_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          div_d = div_q - 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        ss_d    = 1'b1;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase

    // bits_q counts down from a value congruent to 7 mod 8, so its low bits hit 0 on each byte's last bit.
    if (rise) begin
      rx_sh_d = rx_next;
      if (bits_q[2:0] == 3'd0) begin
        rx_byte_d  = rx_next;
        rx_valid_d = 1'b1;
      end
    end

    // Ready lags IDLE entry by one cycle so GAP_CYCLES+1 separates frame end from the next accept.
    cmd_ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
    busy_d      = !cmd_ready_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      div_q        <= 8'd0;
      tx_q         <= 24'h000000;
      bits_q       <= 5'd0;
      last_q       <= 1'b0;
      rx_sh_q      <= 8'h00;
      rx_byte_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      sck_q        <= 1'b0;
      ss_q         <= 1'b1;
      mosi_q       <= 1'b0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      tx_q         <= tx_d;
      bits_q       <= bits_d;
      last_q       <= last_d;
      rx_sh_q      <= rx_sh_d;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      sck_q        <= sck_d;
      ss_q         <= ss_d;
      mosi_q       <= mosi_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.rx_byte     = rx_byte_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.hw_spi_clk  = sck_q;
  assign bus.hw_spi_ss   = ss_q;
  assign bus.hw_spi_mosi = mosi_q;

endmodule
`default_nettype wire
